// File: rtl/wb_byte_bridge.sv
// wb_byte_bridge: converts single-byte host reads/writes into 16-bit Wishbone
// classic cycles. A one-word read buffer serves repeated reads of the same
// word without touching the bus. Writes go to the bus and also update the
// buffer when they hit the same word. A bus cycle that gets no ack within
// TIMEOUT cycles is aborted and reported through host_err.
//
// Handshake: host_req is sampled only while host_busy=0, with no queueing.
// Every accepted request ends with exactly one single-cycle host_done pulse.
// host_err qualifies that pulse. Reset is the one exception: a reset ends a
// request with no pulse. On the Wishbone side cyc/stb stay high until
// wb_ack_i or the timeout. An ack seen outside a bus cycle is ignored.
module wb_byte_bridge #(
    parameter int HOST_ADDR_WIDTH = 25,
    parameter int WB_ADDR_WIDTH   = 24,
    parameter int TIMEOUT         = 255,
    parameter int BUF_EN          = 1
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n_i,
    input  logic                       host_req,
    input  logic                       host_we,
    input  logic [HOST_ADDR_WIDTH-1:0] host_addr,
    input  logic [7:0]                 host_wdata,
    input  logic                       host_flush,
    output logic [7:0]                 host_rdata,
    output logic                       host_done,
    output logic                       host_err,
    output logic                       host_busy,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [15:0]                wb_dat_o,
    output logic [1:0]                 wb_sel_o,
    input  logic [15:0]                wb_dat_i,
    input  logic                       wb_ack_i,
    output logic [1:0]                 dbg_state_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIT  = 2'd1,
        S_BUS  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic                       run_q;
    logic                       cyc_q, cyc_d;
    logic                       we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [1:0]                 sel_q, sel_d;
    logic [15:0]                dat_q, dat_d;
    logic                       lsb_q, lsb_d;
    logic [7:0]                 wdata_q, wdata_d;
    logic [TW-1:0]              tcnt_q, tcnt_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       busy_q, busy_d;
    logic [7:0]                 rdata_q, rdata_d;
    logic                       bvalid_q, bvalid_d;
    logic [WB_ADDR_WIDTH-1:0]   btag_q, btag_d;
    logic [15:0]                bdata_q, bdata_d;
    logic                       hit;

    function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    // A read can be served from the buffer only if this cycle's flush does not kill it.
    assign hit = (BUF_EN != 0) && bvalid_q && !host_flush &&
                 (btag_q == host_addr[HOST_ADDR_WIDTH-1:1]);

    // Reset release gate: the first edge after deassertion arms it, so requests are taken from the second edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) run_q <= 1'b0;
        else             run_q <= 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= S_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            sel_q    <= 2'b00;
            dat_q    <= 16'h0000;
            lsb_q    <= 1'b0;
            wdata_q  <= 8'h00;
            tcnt_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            rdata_q  <= 8'h00;
            bvalid_q <= 1'b0;
            btag_q   <= '0;
            bdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            lsb_q    <= lsb_d;
            wdata_q  <= wdata_d;
            tcnt_q   <= tcnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
            bvalid_q <= bvalid_d;
            btag_q   <= btag_d;
            bdata_q  <= bdata_d;
        end
    end

    // Next-state logic. Outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        lsb_d    = lsb_q;
        wdata_d  = wdata_q;
        tcnt_d   = tcnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        bvalid_d = host_flush ? 1'b0 : bvalid_q;
        btag_d   = btag_q;
        bdata_d  = bdata_q;

        case (state_q)
            S_IDLE: begin
                if (host_req && run_q) begin
                    we_d    = host_we;
                    lsb_d   = host_addr[0];
                    wdata_d = host_wdata;
                    adr_d   = host_addr[HOST_ADDR_WIDTH-1:1];
                    sel_d   = host_addr[0] ? 2'b10 : 2'b01;
                    if (!host_we && hit) begin
                        state_d = S_HIT;
                        done_d  = 1'b1;
                        rdata_d = pick_byte(bdata_q, host_addr[0]);
                    end else begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        tcnt_d  = '0;
                        dat_d   = host_we ? {host_wdata, host_wdata} : 16'h0000;
                    end
                end
            end
            S_BUS: begin
                tcnt_d = tcnt_q + TW'(1);
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = pick_byte(wb_dat_i, lsb_q);
                        if (BUF_EN != 0) begin
                            // The load overrides a flush in the same cycle.
                            bvalid_d = 1'b1;
                            btag_d   = adr_q;
                            bdata_d  = wb_dat_i;
                        end
                    end else if (btag_q == adr_q) begin
                        if (lsb_q) bdata_d[15:8] = wdata_q;
                        else       bdata_d[7:0]  = wdata_q;
                    end
                end else if (tcnt_d == TW'(TIMEOUT)) begin
                    cyc_d   = 1'b0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 8'hFF;
                end
            end
            S_HIT, S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = sel_q;
    assign wb_dat_o    = dat_q;
    assign host_done   = done_q;
    assign host_err    = err_q;
    assign host_busy   = busy_q;
    assign host_rdata  = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_byte_bridge.sv
// Directed bench for wb_byte_bridge. Stimulus pushes expected host completions
// and expected Wishbone cycles into queues. Independent monitors pop those
// queues and compare them when the DUT raises host_done or starts a bus cycle.
module tb_wb_byte_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_req, host_we, drv_flush, ack_flush, host_flush;
    logic [24:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        host_done, host_err, host_busy;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [23:0] wb_adr_o;
    logic [15:0] wb_dat_o, wb_dat_i;
    logic [1:0]  wb_sel_o, dbg_state;
    logic        slave_ack, force_ack, wb_ack_i;

    int          slave_wait   = 0;
    bit          slave_noack  = 1'b0;
    bit          flush_on_ack = 1'b0;
    logic [15:0] slave_word   = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;
    int last_cyc_len = 0;

    logic [9:0]  exp_done_q[$];   // {check_rdata, err, rdata}
    logic [43:0] exp_wb_q[$];     // {check_dat, we, adr, sel, dat}

    assign host_flush = drv_flush | ack_flush;
    assign wb_ack_i   = slave_ack | force_ack;

    always #5 clk = ~clk;

    wb_byte_bridge dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_flush (host_flush),
        .host_rdata (host_rdata),
        .host_done  (host_done),
        .host_err   (host_err),
        .host_busy  (host_busy),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wishbone slave: acks after slave_wait wait states, optionally flushing in the ack cycle.
    initial begin
        int wcnt;
        wcnt = 0;
        slave_ack = 1'b0;
        ack_flush = 1'b0;
        wb_dat_i  = 16'h0000;
        forever begin
            @(negedge clk);
            ack_flush = 1'b0;
            if (slave_ack) begin
                slave_ack = 1'b0;
                wcnt = 0;
            end else if (wb_cyc_o && wb_stb_o) begin
                if (!slave_noack && wcnt == slave_wait) begin
                    slave_ack = 1'b1;
                    wb_dat_i  = slave_word;
                    if (flush_on_ack) ack_flush = 1'b1;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Wishbone monitor: checks each new bus cycle and measures how long cyc stays high.
    initial begin
        logic        prev_cyc;
        int          cyc_len;
        logic [43:0] e;
        prev_cyc = 1'b0;
        cyc_len  = 0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o && !prev_cyc) begin
                cyc_len = 1;
                if (exp_wb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wb_unexpected: bus cycle adr=0x%0h, none expected", wb_adr_o);
                end else begin
                    e = exp_wb_q.pop_front();
                    check("wb_stb", 64'(wb_stb_o), 64'(1'b1));
                    check("wb_we",  64'(wb_we_o),  64'(e[42]));
                    check("wb_adr", 64'(wb_adr_o), 64'(e[41:18]));
                    check("wb_sel", 64'(wb_sel_o), 64'(e[17:16]));
                    if (e[43]) check("wb_dat", 64'(wb_dat_o), 64'(e[15:0]));
                end
            end else if (wb_cyc_o) begin
                cyc_len++;
            end else if (prev_cyc) begin
                last_cyc_len = cyc_len;
            end
            prev_cyc = wb_cyc_o;
        end
    end

    // Host completion monitor.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (host_done) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: host_done with rdata=0x%0h err=%0b", host_rdata, host_err);
                end else begin
                    e = exp_done_q.pop_front();
                    check("done_err", 64'(host_err), 64'(e[8]));
                    if (e[9]) check("done_rdata", 64'(host_rdata), 64'(e[7:0]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (host_busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(host_busy), 64'(1'b0));
    endtask

    task automatic issue(input logic we, input logic [24:0] addr, input logic [7:0] wd);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        @(negedge clk);
        host_req   = 1'b0;
    endtask

    task automatic push_done(input logic chk, input logic err, input logic [7:0] rd);
        exp_done_q.push_back({chk, err, rd});
    endtask

    task automatic push_wb(input logic chk, input logic we, input logic [23:0] adr,
                           input logic [1:0] sel, input logic [15:0] dat);
        exp_wb_q.push_back({chk, we, adr, sel, dat});
    endtask

    task automatic read_miss(input logic [24:0] addr, input logic [15:0] word, input int wt,
                             input logic [23:0] e_adr, input logic [1:0] e_sel, input logic [7:0] e_byte);
        slave_word = word;
        slave_wait = wt;
        push_wb(1'b0, 1'b0, e_adr, e_sel, 16'h0000);
        push_done(1'b1, 1'b0, e_byte);
        issue(1'b0, addr, 8'h00);
        wait_idle("miss_idle");
    endtask

    task automatic read_hit(input logic [24:0] addr, input logic [7:0] e_byte);
        push_done(1'b1, 1'b0, e_byte);
        issue(1'b0, addr, 8'h00);
        check("hit_latency", 64'(host_done), 64'(1'b1));
        check("hit_no_cyc",  64'(wb_cyc_o),  64'(1'b0));
        wait_idle("hit_idle");
    endtask

    task automatic write_op(input logic [24:0] addr, input logic [7:0] wd, input int wt,
                            input logic [23:0] e_adr, input logic [1:0] e_sel, input logic [15:0] e_dat);
        slave_wait = wt;
        push_wb(1'b1, 1'b1, e_adr, e_sel, e_dat);
        push_done(1'b0, 1'b0, 8'h00);
        issue(1'b1, addr, wd);
        wait_idle("write_idle");
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 8'h00;
        drv_flush = 1'b0; force_ack = 1'b0;
        tick(3);

        // Reset values.
        check("rst_cyc",   64'(wb_cyc_o),   64'(1'b0));
        check("rst_stb",   64'(wb_stb_o),   64'(1'b0));
        check("rst_we",    64'(wb_we_o),    64'(1'b0));
        check("rst_sel",   64'(wb_sel_o),   64'(2'b00));
        check("rst_adr",   64'(wb_adr_o),   64'(24'h0));
        check("rst_dat",   64'(wb_dat_o),   64'(16'h0));
        check("rst_done",  64'(host_done),  64'(1'b0));
        check("rst_err",   64'(host_err),   64'(1'b0));
        check("rst_busy",  64'(host_busy),  64'(1'b0));
        check("rst_rdata", 64'(host_rdata), 64'(8'h00));
        check("rst_state", 64'(dbg_state),  64'(2'd0));

        // Release with a request already pending: taken on the second rising edge.
        // Read miss at 0x000101: word 0x80, high lane, slave returns A55A after 3 waits.
        slave_word = 16'hA55A;
        slave_wait = 3;
        push_wb(1'b0, 1'b0, 24'h000080, 2'b10, 16'h0000);
        push_done(1'b1, 1'b0, 8'hA5);
        rst_n = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 25'h000101;
        @(negedge clk);
        check("sync_edge1_busy", 64'(host_busy), 64'(1'b0));
        @(negedge clk);
        check("sync_edge2_busy", 64'(host_busy), 64'(1'b1));
        host_req = 1'b0;
        wait_idle("first_miss_idle");

        // Other byte of the buffered word hits.
        read_hit(25'h000100, 8'h5A);

        // Write-through to the low byte, then both bytes hit.
        write_op(25'h000100, 8'h3C, 1, 24'h000080, 2'b01, 16'h3C3C);
        read_hit(25'h000100, 8'h3C);
        read_hit(25'h000101, 8'hA5);

        // Flush forces a miss.
        drv_flush = 1'b1;
        tick(1);
        drv_flush = 1'b0;
        read_miss(25'h000100, 16'h1234, 0, 24'h000080, 2'b01, 8'h34);

        // Write to another word leaves the buffer alone.
        write_op(25'h000201, 8'h77, 2, 24'h000100, 2'b10, 16'h7777);
        read_hit(25'h000100, 8'h34);

        // Flush in the same cycle as a read-ack load: the load wins.
        flush_on_ack = 1'b1;
        read_miss(25'h000300, 16'hBEEF, 2, 24'h000180, 2'b01, 8'hEF);
        flush_on_ack = 1'b0;
        read_hit(25'h000301, 8'hBE);

        // Stray ack while idle is ignored.
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        tick(2);
        check("stray_ack_busy",  64'(host_busy), 64'(1'b0));
        check("stray_ack_state", 64'(dbg_state), 64'(2'd0));
        read_hit(25'h000300, 8'hEF);

        // Timeout: no ack, cyc held for 255 cycles, error completion with FF.
        slave_noack = 1'b1;
        push_wb(1'b0, 1'b0, 24'h000200, 2'b01, 16'h0000);
        push_done(1'b1, 1'b1, 8'hFF);
        issue(1'b0, 25'h000400, 8'h00);
        wait_idle("timeout_idle");
        check("timeout_len", 64'(last_cyc_len), 64'(255));
        slave_noack = 1'b0;
        read_hit(25'h000301, 8'hBE);

        // A request raised while busy is dropped, not queued.
        slave_wait = 6;
        push_wb(1'b1, 1'b1, 24'h000280, 2'b01, 16'h5555);
        push_done(1'b0, 1'b0, 8'h00);
        issue(1'b1, 25'h000500, 8'h55);
        host_req = 1'b1; host_we = 1'b0; host_addr = 25'h000301;
        tick(2);
        host_req = 1'b0;
        wait_idle("busy_req_idle");
        tick(3);
        check("busy_req_dropped", 64'(host_busy), 64'(1'b0));

        // Reset in the middle of a bus wait.
        slave_noack = 1'b1;
        push_wb(1'b0, 1'b0, 24'h000300, 2'b01, 16'h0000);
        issue(1'b0, 25'h000600, 8'h00);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cyc",   64'(wb_cyc_o),  64'(1'b0));
        check("midrst_stb",   64'(wb_stb_o),  64'(1'b0));
        check("midrst_busy",  64'(host_busy), 64'(1'b0));
        check("midrst_state", 64'(dbg_state), 64'(2'd0));
        tick(2);
        rst_n = 1'b1;
        slave_noack = 1'b0;
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        tick(2);
        check("late_ack_busy", 64'(host_busy), 64'(1'b0));

        // Buffer was invalidated by reset: 0x301 misses now.
        read_miss(25'h000301, 16'hC0DE, 1, 24'h000180, 2'b10, 8'hC0);

        tick(10);
        check("done_queue_empty", 64'(exp_done_q.size()), 64'(0));
        check("wb_queue_empty",   64'(exp_wb_q.size()),   64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
